// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the MA-stage access controller (master) and dmem (slave).
// Carries the read/write strobes, address, write data and the dmem response.
interface dmem_access_ctrl_if;
    logic [3:0]  read;
    logic [2:0]  write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        busywait;

    modport master (
        output read,
        output write,
        output address,
        output writedata,
        input  readdata,
        input  busywait
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  writedata,
        output readdata,
        output busywait
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MA-stage data-memory initiator: issues dmem read/write codes, stalls the pipeline until
// dmem completes, and flags faults. Define MEM_TIMEOUT_EN to abort accesses stuck busy.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned TIMEOUT_W      = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       alu_addr,
    input  logic [31:0]       store_data,
    output logic              mem_stall,
    output logic [31:0]       load_data,
    output logic              mem_fault,
    output logic [1:0]        fault_cause,
    dmem_access_ctrl_if.master dmem
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_param_err
        $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    localparam logic [1:0] CauseNone     = 2'b00;
    localparam logic [1:0] CauseMisalign = 2'b01;
    localparam logic [1:0] CauseIllegal  = 2'b10;
    localparam logic [1:0] CauseTimeout  = 2'b11;

    state_e      state_q, state_d;
    logic [3:0]  read_q, read_d;
    logic [2:0]  write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_q, load_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

`ifdef MEM_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
`endif

    logic [3:0] rd_code;
    logic [2:0] wr_code;
    logic       illegal;
    logic       misaligned;

    // Request decode; illegal is evaluated first so it wins over misalignment.
    always_comb begin
        rd_code    = 4'b0000;
        wr_code    = 3'b000;
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (mem_read && mem_write) begin
            illegal = 1'b1;
        end else if (mem_read) begin
            case (funct3)
                3'b000: rd_code = 4'b1010;
                3'b001: begin rd_code = 4'b1001; misaligned = alu_addr[0];    end
                3'b010: begin rd_code = 4'b1000; misaligned = |alu_addr[1:0]; end
                3'b100: rd_code = 4'b1110;
                3'b101: begin rd_code = 4'b1101; misaligned = alu_addr[0];    end
                default: illegal = 1'b1;
            endcase
        end else if (mem_write) begin
            case (funct3)
                3'b000: wr_code = 3'b110;
                3'b001: begin wr_code = 3'b101; misaligned = alu_addr[0];    end
                3'b010: begin wr_code = 3'b100; misaligned = |alu_addr[1:0]; end
                default: illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        read_d  = read_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        fault_d = fault_q;
        cause_d = cause_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    if (illegal || misaligned) begin
                        fault_d = 1'b1;
                        cause_d = illegal ? CauseIllegal : CauseMisalign;
                        state_d = StDone;
                    end else begin
                        read_d  = rd_code;
                        write_d = wr_code;
                        addr_d  = alu_addr;
                        wdata_d = store_data;
                        state_d = StAccess;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            StAccess: begin
                if (!dmem.busywait) begin
                    if (read_q[3]) begin
                        load_d = dmem.readdata;
                    end
                    read_d  = 4'b0000;
                    write_d = 3'b000;
                    state_d = StDone;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == TimeoutLast) begin
                    read_d  = 4'b0000;
                    write_d = 3'b000;
                    fault_d = 1'b1;
                    cause_d = CauseTimeout;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StDone: begin
                fault_d = 1'b0;
                cause_d = CauseNone;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            read_q  <= '0;
            write_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= '0;
            fault_q <= 1'b0;
            cause_q <= CauseNone;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            read_q  <= read_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign mem_stall = reset & (((state_q == StIdle) & (mem_read | mem_write)) |
                                (state_q == StAccess));

    assign load_data      = load_q;
    assign mem_fault      = fault_q;
    assign fault_cause    = cause_q;
    assign dmem.read      = read_q;
    assign dmem.write     = write_q;
    assign dmem.address   = addr_q;
    assign dmem.writedata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed scenarios then random requests,
// all checked against a rule-level model of codes, faults and stall timing.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] alu_addr = '0;
    logic [31:0] store_data = '0;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        mem_fault;
    logic [1:0]  fault_cause;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] ref_load = '0;

    dmem_access_ctrl_if dmem_bus ();

    dmem_access_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_W     (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .alu_addr   (alu_addr),
        .store_data (store_data),
        .mem_stall  (mem_stall),
        .load_data  (load_data),
        .mem_fault  (mem_fault),
        .fault_cause(fault_cause),
        .dmem       (dmem_bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Rule-level model: access size from funct3, codes built as {en, unsigned, size}.
    task automatic model(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, output logic [3:0] erd,
                         output logic [2:0] ewr, output logic [1:0] cause);
        int  size;
        bit  legal_load, legal_store, bad, mis;
        logic [1:0] szc;
        legal_load  = (f3[1:0] != 2'd3) && (f3 != 3'd6);
        legal_store = (f3 < 3'd3);
        bad  = (rd && wr) || (rd && !legal_load) || (wr && !legal_store);
        size = 1 << f3[1:0];
        mis  = (a % size) != 0;
        szc  = 2'(2 - f3[1:0]);
        erd  = rd ? {1'b1, f3[2], szc} : 4'b0;
        ewr  = wr ? {1'b1, szc} : 3'b0;
        cause = bad ? 2'b10 : (mis ? 2'b01 : 2'b00);
    endtask

    // Starts just after a rising edge with the controller idle; ends likewise.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdata, input int busy);
        logic [3:0] erd;
        logic [2:0] ewr;
        logic [1:0] ecause;
        int  acc_cycles;
        bit  tout;
        model(rd, wr, f3, a, erd, ewr, ecause);
        mem_read = rd; mem_write = wr; funct3 = f3; alu_addr = a; store_data = wd;
        dmem_bus.readdata = rdata;
        dmem_bus.busywait = (busy > 0);
        @(negedge clock);
        check("idle_stall", mem_stall, 1);
        check("idle_read", dmem_bus.read, 0);
        check("idle_write", dmem_bus.write, 0);
        @(posedge clock); #1;
        if (ecause == 2'b00) begin
            tout = TimeoutEn && (busy >= TO);
            acc_cycles = tout ? TO : busy + 1;
            for (int k = 0; k < acc_cycles; k++) begin
                dmem_bus.busywait = (k < busy);
                @(negedge clock);
                check("acc_stall", mem_stall, 1);
                check("acc_read", dmem_bus.read, erd);
                check("acc_write", dmem_bus.write, ewr);
                check("acc_addr", dmem_bus.address, a);
                if (wr) check("acc_wdata", dmem_bus.writedata, wd);
                @(posedge clock); #1;
            end
            if (tout) ecause = 2'b11;
            else if (rd) ref_load = rdata;
        end
        mem_read = 1'b0; mem_write = 1'b0; dmem_bus.busywait = 1'b0;
        @(negedge clock);
        check("done_stall", mem_stall, 0);
        check("done_fault", mem_fault, ecause != 2'b00);
        check("done_cause", fault_cause, ecause);
        check("done_load", load_data, ref_load);
        check("done_read", dmem_bus.read, 0);
        check("done_write", dmem_bus.write, 0);
        @(posedge clock); #1;
        check("post_stall", mem_stall, 0);
        check("post_fault", mem_fault, 0);
        check("post_cause", fault_cause, 0);
        check("post_load", load_data, ref_load);
    endtask

    initial begin
        dmem_bus.readdata = '0;
        dmem_bus.busywait = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_read", dmem_bus.read, 0);
        check("rst_write", dmem_bus.write, 0);
        check("rst_addr", dmem_bus.address, 0);
        check("rst_wdata", dmem_bus.writedata, 0);
        check("rst_load", load_data, 0);
        check("rst_fault", mem_fault, 0);
        check("rst_cause", fault_cause, 0);
        check("rst_stall", mem_stall, 0);
        reset = 1'b1;

        // Reset asserted mid-ACCESS with a store pending.
        mem_write = 1'b1; funct3 = 3'b010; alu_addr = 32'h4; store_data = 32'h1234_5678;
        dmem_bus.busywait = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("midrst_write_before", dmem_bus.write, 3'b100);
        #1 reset = 1'b0;
        #1;
        check("midrst_read", dmem_bus.read, 0);
        check("midrst_write", dmem_bus.write, 0);
        check("midrst_stall", mem_stall, 0);
        mem_write = 1'b0; dmem_bus.busywait = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        check("midrst_idle_stall", mem_stall, 0);

        // Directed scenarios.
        access(1'b0, 1'b1, 3'b010, 32'h04, 32'hAABBCCDD, 32'h0, 2);   // SW, 2 wait
        access(1'b1, 1'b0, 3'b010, 32'h04, 32'h0, 32'hAABBCCDD, 2);   // LW, 2 wait
        access(1'b1, 1'b0, 3'b001, 32'h09, 32'h0, 32'h1111_1111, 0);  // LH misaligned
        access(1'b1, 1'b0, 3'b100, 32'h09, 32'h0, 32'h0000_00EE, 0);  // LBU ok
        access(1'b1, 1'b1, 3'b010, 32'h08, 32'h5, 32'h2222_2222, 0);  // both -> illegal
        access(1'b1, 1'b0, 3'b011, 32'h08, 32'h0, 32'h3333_3333, 0);  // load 011 illegal
        access(1'b0, 1'b1, 3'b011, 32'h03, 32'h7, 32'h0, 0);          // illegal beats misalign
        access(1'b0, 1'b1, 3'b010, 32'h06, 32'h9, 32'h0, 0);          // SW misaligned
        access(1'b0, 1'b1, 3'b000, 32'h07, 32'hCAFE_F00D, 32'h0, 1);  // SB leaves load_data

        // Busywait stuck: aborts with timeout when enabled, otherwise waits it out.
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 100);

        for (int i = 0; i < 40; i++) begin
            int  sel;
            sel = $urandom_range(1, 3);
            access(sel[0], sel[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
